// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder (with its four_bit_adder ripple slice)
// Purpose  : Multi-cycle WIDTH-bit adder. One 4-bit ripple slice is reused
//            NIB = WIDTH/4 times, least significant nibble first, with the
//            carry held in a register between steps.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            in_valid/in_ready     - operand handshake (a, b, cin)
//            out_valid/out_ready   - result handshake (sum, cout, ovf)
//            a, b   [WIDTH-1:0]    - operands
//            cin                   - carry into bit 0
//            sum    [WIDTH-1:0]    - a + b + cin modulo 2^WIDTH
//            cout                  - carry out of bit WIDTH-1
//            ovf                   - signed overflow
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// four_bit_adder: plain 4-bit ripple-carry slice.
// Ports: x, y [3:0], cin -> s [3:0], cout
// ----------------------------------------------------------------------------
module four_bit_adder (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] w_c;

  assign w_c[0] = cin;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fa
    assign s[gi]     = x[gi] ^ y[gi] ^ w_c[gi];
    assign w_c[gi+1] = (x[gi] & y[gi]) | (w_c[gi] & (x[gi] ^ y[gi]));
  end

  assign cout = w_c[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NIB = WIDTH / 4;
  // Index needs at least one bit even for a single-nibble instance.
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] C_LAST = IW'(NIB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q,   idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;

  logic [IW+1:0]    w_base;
  logic [3:0]       w_slice_s;
  logic             w_slice_c;

  // Bit offset of the current nibble.
  assign w_base = {idx_q, 2'b00};

  four_bit_adder u_slice (
    .x    (a_q[w_base +: 4]),
    .y    (b_q[w_base +: 4]),
    .cin  (carry_q),
    .s    (w_slice_s),
    .cout (w_slice_c)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        sum_d[w_base +: 4] = w_slice_s;
        carry_d            = w_slice_c;
        if (idx_q == C_LAST) begin
          cout_d  = w_slice_c;
          // Carry into the MSB is recovered from the MSB sum bit and its
          // operand bits, then compared with the carry leaving the MSB.
          ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ w_slice_s[3] ^ w_slice_c;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder
// Purpose  : Self-checking bench for nibble_serial_adder, WIDTH=16 and
//            WIDTH=4 instances, with a queue of expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;
  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        cin, cout, ovf;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]  a4, b4, sum4;
  logic        cin4, cout4, ovf4;

  exp_t q16[$];
  exp_t q4[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  nibble_serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb,
                                 input logic tc, input int w);
    exp_t        e;
    logic [16:0] full;
    logic [15:0] mask;
    mask   = (w == 16) ? 16'hFFFF : 16'h000F;
    full   = {1'b0, ta & mask} + {1'b0, tb & mask} + {16'd0, tc};
    e.s    = full[15:0] & mask;
    e.c    = full[w];
    e.o    = (ta[w-1] == tb[w-1]) && (full[w-1] != ta[w-1]);
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_valid4 = 1'b1;
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    out_ready = 1'b1; out_ready4 = 1'b1;
    tick(); tick();
    vectors++;
    if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset16: got rdy=%b vld=%b sum=%h c=%b o=%b, want rdy=1 vld=0 sum=0 c=0 o=0",
               in_ready, out_valid, sum, cout, ovf);
    end
    vectors++;
    if ({in_ready4, out_valid4, sum4, cout4, ovf4} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset4: got rdy=%b vld=%b sum=%h c=%b o=%b, want rdy=1 vld=0 sum=0 c=0 o=0",
               in_ready4, out_valid4, sum4, cout4, ovf4);
    end
    rst = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0;
  endtask

  // Runs one WIDTH=16 operation; checks latency and result. Retirement is
  // checked only when out_ready is high.
  task automatic do_op16(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
    exp_t e;
    int   n;
    q16.push_back(model(ta, tb, tc, 16));
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    vectors++;
    if (n !== 4) begin
      miscompares++;
      $display("FAIL latency16 %h+%h: got %0d edges, want 4", ta, tb, n);
    end
    e = q16.pop_front();
    vectors++;
    if ({sum, cout, ovf} !== {e.s, e.c, e.o}) begin
      miscompares++;
      $display("FAIL result16 %h+%h+%b: got sum=%h c=%b o=%b, want sum=%h c=%b o=%b",
               ta, tb, tc, sum, cout, ovf, e.s, e.c, e.o);
    end
    if (out_ready) begin
      tick();
      vectors++;
      if ({in_ready, out_valid} !== 2'b10) begin
        miscompares++;
        $display("FAIL retire16: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
      end
    end
  endtask

  task automatic test_arith();
    do_op16(16'h1234, 16'h4321, 1'b0);
    do_op16(16'hFFFF, 16'h0001, 1'b0);
    do_op16(16'h7FFF, 16'h0001, 1'b0);
    do_op16(16'h0000, 16'h0000, 1'b1);
    do_op16(16'h8000, 16'h8000, 1'b0);
    do_op16(16'h0FFF, 16'h0000, 1'b1);
    for (int i = 0; i < 4; i++)
      do_op16(16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  task automatic test_backpressure();
    logic [17:0] held;
    int          bad;
    out_ready = 1'b0;
    do_op16(16'h9ABC, 16'hDEF0, 1'b1);
    held = {sum, cout, ovf};
    bad  = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
      tick();
      if ({sum, cout, ovf} !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL backpressure_hold: got %0d bad cycles, want 0", bad);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL backpressure_release: got rdy=%b vld=%b, want rdy=1 vld=0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_reset_midop();
    int seen;
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; in_valid = 1'b1;
    tick();                 // accept edge: now in ADD cycle 1
    in_valid = 1'b0;
    tick();                 // now in ADD cycle 2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_midop: got rdy=%b vld=%b sum=%h c=%b o=%b, want rdy=1 vld=0 sum=0 c=0 o=0",
               in_ready, out_valid, sum, cout, ovf);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL reset_no_valid: got %0d out_valid cycles, want 0", seen);
    end
    do_op16(16'h0002, 16'h0003, 1'b0);
  endtask

  task automatic do_op4(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
    exp_t e;
    int   n;
    q4.push_back(model({12'd0, ta}, {12'd0, tb}, tc, 4));
    n = 0;
    while (!in_ready4 && n < 50) begin tick(); n++; end
    a4 = ta; b4 = tb; cin4 = tc; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    n = 0;
    while (!out_valid4 && n < 20) begin tick(); n++; end
    vectors++;
    if (n !== 1) begin
      miscompares++;
      $display("FAIL latency4 %h+%h: got %0d edges, want 1", ta, tb, n);
    end
    e = q4.pop_front();
    vectors++;
    if ({sum4, cout4, ovf4} !== {e.s[3:0], e.c, e.o}) begin
      miscompares++;
      $display("FAIL result4 %h+%h+%b: got sum=%h c=%b o=%b, want sum=%h c=%b o=%b",
               ta, tb, tc, sum4, cout4, ovf4, e.s[3:0], e.c, e.o);
    end
    tick();
  endtask

  task automatic test_width4();
    do_op4(4'h9, 4'h8, 1'b1);
    do_op4(4'h7, 4'h1, 1'b0);
    do_op4(4'h3, 4'h4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_midop();
    test_width4();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder that feeds operand nibbles, least significant first, into one four_bit_adder stage and consumes each 4-bit sum/cout it produces.
- Sits directly upstream and downstream of the 4-bit ripple slice. It trades latency (WIDTH/4 cycles) for area, in place of chaining WIDTH/4 slices.
- Uses valid/ready handshakes on both the operand side and the result side.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
- NIB, WIDTH/4 (derived localparam, not overridable), number of nibble steps.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  result fields valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset:
  - The reset condition is rst high at a rising clk edge (synchronous, active-high).
  - It forces state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, and clears the nibble index and carry registers.
  - Reset overrides every other input in the same cycle.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept happens when in_valid && in_ready at an edge. On accept: latch a, b and cin into the operand and carry registers, clear the index to 0, and go to ADD.
  - Inputs are ignored after the accept edge.
- ADD:
  - in_ready=0.
  - Each cycle, drive the slice with x=a_reg[4i+3:4i], y=b_reg[4i+3:4i] and cin=carry_reg, where i is the current index.
  - At the edge: write the slice sum into sum[4i+3:4i], load the slice cout into carry_reg, and increment i.
  - On the edge where i==NIB-1:
    - load cout from the slice cout;
    - set ovf = (carry into bit WIDTH-1) XOR (slice cout), where the carry into bit WIDTH-1 is a_reg[W-1]^b_reg[W-1]^sum bit W-1;
    - go to DONE.
  - Partial sum bits are not valid until DONE.
- Latency: out_valid rises exactly NIB edges after the accept edge. For WIDTH=4 that is 1 edge; for WIDTH=16 it is 4 edges.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, cout and ovf are held stable until the handshake completes.
  - On out_valid && out_ready at an edge: go to IDLE and drop out_valid. in_ready returns to 1 in the next cycle.
  - A new operand cannot be accepted in the same cycle as result retirement.
- Result registers keep their last value after retirement; they are don't-care while out_valid=0.
- Throughput: one operation per NIB+2 cycles with no backpressure.
- Arithmetic: all arithmetic is modulo 2^WIDTH. The carry chain is purely through carry_reg; no carry is lost between nibbles.
- Boundary conditions:
  - in_valid asserted during ADD or DONE is ignored; the upstream source must hold it until in_ready.
  - out_ready asserted outside DONE has no effect.
  - rst during ADD or DONE abandons the operation with no out_valid pulse; the next accept starts cleanly.
  - The index wraps only through the DONE to IDLE path; it never exceeds NIB-1.

Test Plan:
- WIDTH=16: a=0x1234, b=0x4321, cin=0, out_ready=1 -> out_valid exactly 4 edges after accept; sum=0x5555, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Repeat with a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- a=0x0000, b=0x0000, cin=1 -> sum=0x0001. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, toggling a/b/in_valid -> sum/cout/ovf unchanged and in_ready=0 throughout. Release -> IDLE, in_ready=1 next cycle.
- Reset mid-op: accept 0x0F0F+0x0101, assert rst on the 2nd ADD cycle -> no out_valid, all outputs 0. Then 0x0002+0x0003 -> sum=0x0005 after 4 edges.
- WIDTH=4 instance: a=0x9, b=0x8, cin=1 -> 1-edge latency; sum=0x2, cout=1, ovf=1.
